// File: rtl/maze_pkg.sv
// Shared definitions for the maze renderer: tile encodings, palette and the
// initial maze layout.
package maze_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_WALL   = 2'd1,
    TILE_PELLET = 2'd2,
    TILE_POWER  = 2'd3
  } tile_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ren_state_t;

  localparam logic [11:0] BG_COLOR     = 12'h000;
  localparam logic [11:0] WALL_COLOR   = 12'h22F;
  localparam logic [11:0] PELLET_COLOR = 12'hFDB;
  localparam logic [11:0] POWER_COLOR  = 12'hF80;

  // Tiles that count towards pellets_left and are cleared when eaten.
  function automatic logic is_food(tile_t t);
    return (t == TILE_PELLET) || (t == TILE_POWER);
  endfunction

  // Initial layout: walled border, power pellets in the inner corners,
  // a sparse grid of interior walls, an empty centre tile, pellets elsewhere.
  function automatic tile_t init_tile(int row, int col, int rows, int cols);
    if (row == 0 || row == rows - 1 || col == 0 || col == cols - 1) return TILE_WALL;
    if ((row == 1 || row == rows - 2) && (col == 1 || col == cols - 2)) return TILE_POWER;
    if ((row % 3 == 0) && (col % 3 == 0)) return TILE_WALL;
    if (row == rows / 2 && col == cols / 2) return TILE_EMPTY;
    return TILE_PELLET;
  endfunction

endpackage

// File: rtl/maze_renderer_if.sv
// Pixel request/colour, eat handshake and status signals of the maze renderer.
interface maze_renderer_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int COLOR_W = 12
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(ROWS * COLS + 1);

  logic               pix_valid;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [COLOR_W-1:0] color;
  logic               color_valid;
  logic               eat_valid;
  logic               eat_ready;
  logic [RW-1:0]      eat_row;
  logic [CW-1:0]      eat_col;
  logic               eat_done;
  logic [1:0]         eat_kind;
  logic               restart;
  logic [PW-1:0]      pellets_left;
  logic               level_clear;

  modport master (
    output pix_valid, pix_x, pix_y, eat_valid, eat_row, eat_col, restart,
    input  color, color_valid, eat_ready, eat_done, eat_kind, pellets_left, level_clear
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, eat_valid, eat_row, eat_col, restart,
    output color, color_valid, eat_ready, eat_done, eat_kind, pellets_left, level_clear
  );
endinterface

// File: rtl/maze_tile_ram.sv
// Tile map storage: port A is read-only for rendering, port B is read/write
// for initialisation and eating. Reads return the value held before a
// same-edge write.
module maze_tile_ram
  import maze_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  output tile_t         a_data,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  tile_t         b_wdata,
  output tile_t         b_rdata
);

  tile_t mem [DEPTH];

  // Render read port.
  // NOTE: storage and its read registers carry no reset; INIT rewrites every entry before use.
  // NOTE: registered state is always assigned with <= so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    a_data <= mem[a_addr];
  end

  // Init/eat read-modify-write port (read-before-write).
  always_ff @(posedge clk) begin
    b_rdata <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/maze_renderer.sv
// Tile-based maze renderer: two-stage pixel pipeline over a tile map, plus an
// eat (clear tile) read-modify-write path and pellet bookkeeping.
module maze_renderer
  import maze_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int TILE_SHIFT = 4,
  parameter int COLOR_W    = 12
) (
  input logic            clk,
  input logic            rst_n,
  maze_renderer_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(N + 1);
  localparam int T  = 1 << TILE_SHIFT;

  localparam logic [TILE_SHIFT-1:0] PEL_LO = TILE_SHIFT'(T / 2 - T / 8);
  localparam logic [TILE_SHIFT-1:0] PEL_HI = TILE_SHIFT'(T / 2 + T / 8);
  localparam logic [TILE_SHIFT-1:0] POW_LO = TILE_SHIFT'(T / 4);
  localparam logic [TILE_SHIFT-1:0] POW_HI = TILE_SHIFT'(3 * T / 4);

  localparam logic [COLOR_W-1:0] C_BG     = COLOR_W'(BG_COLOR);
  localparam logic [COLOR_W-1:0] C_WALL   = COLOR_W'(WALL_COLOR);
  localparam logic [COLOR_W-1:0] C_PELLET = COLOR_W'(PELLET_COLOR);
  localparam logic [COLOR_W-1:0] C_POWER  = COLOR_W'(POWER_COLOR);

  ren_state_t    state;
  logic [IW-1:0] init_idx;
  logic [IW-1:0] pellets_left;
  logic          eat_busy;
  logic          eat_in_range;
  logic [AW-1:0] eat_addr;
  logic          eat_ready;
  logic          eat_done;
  tile_t         eat_kind;

  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          b_we;
  tile_t         a_data;
  tile_t         b_rdata;
  tile_t         b_wdata;
  tile_t         init_data;

  logic [9:0]    tile_row;
  logic [9:0]    tile_col;
  logic          pix_in_grid;
  logic          eat_req_in_range;
  logic [AW-1:0] eat_req_addr;

  logic                  s1_valid;
  logic                  s1_show;
  logic [TILE_SHIFT-1:0] s1_off_x;
  logic [TILE_SHIFT-1:0] s1_off_y;
  logic [COLOR_W-1:0]    pix_color;
  logic [COLOR_W-1:0]    color_q;
  logic                  color_valid_q;

  assign tile_row    = bus.pix_y >> TILE_SHIFT;
  assign tile_col    = bus.pix_x >> TILE_SHIFT;
  assign pix_in_grid = (int'(tile_row) < ROWS) && (int'(tile_col) < COLS);
  assign a_addr      = pix_in_grid ? AW'(int'(tile_row) * COLS + int'(tile_col)) : '0;

  assign eat_req_in_range = (int'(bus.eat_row) < ROWS) && (int'(bus.eat_col) < COLS);
  assign eat_req_addr     = eat_req_in_range ? AW'(int'(bus.eat_row) * COLS + int'(bus.eat_col)) : '0;

  assign init_data = init_tile(int'(init_idx) / COLS, int'(init_idx) % COLS, ROWS, COLS);

  // Port B owner: INIT writes the layout, a pending eat clears food, else eat lookup.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    b_addr  = eat_req_addr;
    b_we    = 1'b0;
    b_wdata = TILE_EMPTY;
    if (state == ST_INIT) begin
      b_addr  = AW'(init_idx);
      b_we    = (init_idx < IW'(N));
      b_wdata = init_data;
    end else if (eat_busy) begin
      b_addr = eat_addr;
      b_we   = eat_in_range && is_food(b_rdata) && !bus.restart;
    end
  end

  maze_tile_ram #(.DEPTH(N)) u_ram (
    .clk     (clk),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

  // Pipeline stage 1: capture request qualifiers alongside the tile read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_show  <= 1'b0;
      s1_off_x <= '0;
      s1_off_y <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_show  <= pix_in_grid && (state == ST_RUN);
      s1_off_x <= bus.pix_x[TILE_SHIFT-1:0];
      s1_off_y <= bus.pix_y[TILE_SHIFT-1:0];
    end
  end

  // Colour selection from tile type and in-tile offset.
  always_comb begin
    pix_color = C_BG;
    if (s1_valid && s1_show) begin
      case (a_data)
        TILE_WALL:   pix_color = C_WALL;
        TILE_PELLET: if (s1_off_x >= PEL_LO && s1_off_x < PEL_HI &&
                         s1_off_y >= PEL_LO && s1_off_y < PEL_HI) pix_color = C_PELLET;
        TILE_POWER:  if (s1_off_x >= POW_LO && s1_off_x < POW_HI &&
                         s1_off_y >= POW_LO && s1_off_y < POW_HI) pix_color = C_POWER;
        default:     pix_color = C_BG;
      endcase
    end
  end

  // Pipeline stage 2: registered colour output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q       <= C_BG;
      color_valid_q <= 1'b0;
    end else begin
      color_q       <= pix_color;
      color_valid_q <= s1_valid;
    end
  end

  // Control FSM: layout load, restart and the two-cycle eat transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      init_idx     <= '0;
      pellets_left <= '0;
      eat_busy     <= 1'b0;
      eat_in_range <= 1'b0;
      eat_addr     <= '0;
      eat_ready    <= 1'b0;
      eat_done     <= 1'b0;
      eat_kind     <= TILE_EMPTY;
    end else begin
      eat_done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_idx == IW'(N)) begin
            state     <= ST_RUN;
            eat_ready <= 1'b1;
          end else begin
            init_idx <= init_idx + 1'b1;
            if (is_food(init_data)) pellets_left <= pellets_left + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.restart) begin
            state        <= ST_INIT;
            init_idx     <= '0;
            pellets_left <= '0;
            eat_busy     <= 1'b0;
            eat_ready    <= 1'b0;
          end else if (eat_busy) begin
            eat_busy  <= 1'b0;
            eat_ready <= 1'b1;
            eat_done  <= 1'b1;
            eat_kind  <= eat_in_range ? b_rdata : TILE_EMPTY;
            if (eat_in_range && is_food(b_rdata)) pellets_left <= pellets_left - 1'b1;
          end else if (bus.eat_valid && eat_ready) begin
            eat_busy     <= 1'b1;
            eat_ready    <= 1'b0;
            eat_addr     <= eat_req_addr;
            eat_in_range <= eat_req_in_range;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.color        = color_q;
  assign bus.color_valid  = color_valid_q;
  assign bus.eat_ready    = eat_ready;
  assign bus.eat_done     = eat_done;
  assign bus.eat_kind     = eat_kind;
  assign bus.pellets_left = pellets_left;
  assign bus.level_clear  = (state == ST_RUN) && (pellets_left == '0);

endmodule

// File: tb/tb_maze_renderer.sv
// Self-checking bench for maze_renderer: a map model built from a picture of
// the expected layout, randomized pixel streams and eats, restart and reset.
module tb_maze_renderer;
  import maze_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int T    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  maze_renderer_if #(.ROWS(ROWS), .COLS(COLS), .COLOR_W(12)) bus ();

  maze_renderer #(.ROWS(ROWS), .COLS(COLS), .TILE_SHIFT(4), .COLOR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // W wall, . pellet, O power, - empty
  string layout [ROWS] = '{
    "WWWWWWWW",
    "WO....OW",
    "W......W",
    "W..W..WW",
    "W...-..W",
    "W......W",
    "WO.W..OW",
    "WWWWWWWW"
  };

  int exp_map [ROWS][COLS];
  int exp_pellets;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    int v;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   px_q[$];
  int   py_q[$];

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int tile_code(byte ch);
    case (ch)
      "W":     return 1;
      ".":     return 2;
      "O":     return 3;
      default: return 0;
    endcase
  endfunction

  task automatic load_layout();
    string s;
    exp_pellets = 0;
    for (int r = 0; r < ROWS; r++) begin
      s = layout[r];
      for (int c = 0; c < COLS; c++) begin
        exp_map[r][c] = tile_code(s[c]);
        if (exp_map[r][c] >= 2) exp_pellets++;
      end
    end
  endtask

  function automatic int model_color(int x, int y);
    int tr = y / T;
    int tc = x / T;
    int ox = x % T;
    int oy = y % T;
    if (tr >= ROWS || tc >= COLS) return int'(BG_COLOR);
    case (exp_map[tr][tc])
      1: return int'(WALL_COLOR);
      2: if (ox >= T/2 - T/8 && ox < T/2 + T/8 && oy >= T/2 - T/8 && oy < T/2 + T/8)
           return int'(PELLET_COLOR);
      3: if (ox >= T/4 && ox < 3*T/4 && oy >= T/4 && oy < 3*T/4)
           return int'(POWER_COLOR);
      default: ;
    endcase
    return int'(BG_COLOR);
  endfunction

  // Counts edges until RUN; called just after the edge that started INIT.
  task automatic wait_run(input string tag, input int already);
    int n = already;
    while (bus.eat_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, 65);
    check({tag, "_pellets"}, int'(bus.pellets_left), exp_pellets);
    check({tag, "_level_clear"}, int'(bus.level_clear), 0);
  endtask

  task automatic stream_pixels();
    int   cyc = 0;
    int   x;
    int   y;
    exp_t e;
    while (px_q.size() > 0 || exp_q.size() > 0) begin
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("pix_color", int'(bus.color), e.c);
        check("pix_valid", int'(bus.color_valid), e.v);
      end
      if (px_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        x = px_q.pop_front();
        y = py_q.pop_front();
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
        exp_q.push_back('{due: cyc + 2, v: 1, c: model_color(x, y)});
      end else if (px_q.size() > 0) begin
        bus.pix_valid = 1'b0;
        exp_q.push_back('{due: cyc + 2, v: 0, c: int'(BG_COLOR)});
      end else begin
        bus.pix_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("idle_color", int'(bus.color), int'(BG_COLOR));
    check("idle_valid", int'(bus.color_valid), 0);
  endtask

  task automatic push_pix(input int x, input int y);
    px_q.push_back(x);
    py_q.push_back(y);
  endtask

  task automatic do_eat(input int r, input int c);
    int n = 0;
    int k = exp_map[r][c];
    check("eat_ready_idle", int'(bus.eat_ready), 1);
    bus.eat_valid = 1'b1;
    bus.eat_row   = 3'(r);
    bus.eat_col   = 3'(c);
    @(posedge clk); #1;
    bus.eat_valid = 1'b0;
    check("eat_ready_busy", int'(bus.eat_ready), 0);
    while (bus.eat_done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("eat_latency", n, 1);
    check("eat_kind", int'(bus.eat_kind), k);
    if (k >= 2) begin
      exp_map[r][c] = 0;
      exp_pellets--;
    end
    check("eat_pellets_left", int'(bus.pellets_left), exp_pellets);
    @(posedge clk); #1;
    check("eat_done_pulse", int'(bus.eat_done), 0);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
    load_layout();
    check("restart_pellets", int'(bus.pellets_left), 0);
    check("restart_level_clear", int'(bus.level_clear), 0);
    check("restart_eat_ready", int'(bus.eat_ready), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_color"}, int'(bus.color), int'(BG_COLOR));
    check({tag, "_color_valid"}, int'(bus.color_valid), 0);
    check({tag, "_eat_done"}, int'(bus.eat_done), 0);
    check({tag, "_eat_kind"}, int'(bus.eat_kind), 0);
    check({tag, "_eat_ready"}, int'(bus.eat_ready), 0);
    check({tag, "_pellets"}, int'(bus.pellets_left), 0);
    check({tag, "_level_clear"}, int'(bus.level_clear), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int part;
    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.eat_valid = 1'b0;
    bus.eat_row   = '0;
    bus.eat_col   = '0;
    bus.restart   = 1'b0;
    load_layout();

    // Reset state, then release between edges.
    #22;
    check_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    wait_run("startup_cycles", 0);

    // Directed pixels followed by random ones.
    push_pix(20, 4);   push_pix(200, 4);  push_pix(40, 40);  push_pix(33, 33);
    push_pix(38, 38);  push_pix(42, 40);  push_pix(20, 20);  push_pix(19, 20);
    push_pix(27, 27);  push_pix(28, 20);  push_pix(72, 72);  push_pix(40, 500);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) push_pix($urandom_range(0, 1023), $urandom_range(0, 1023));
      else push_pix($urandom_range(0, 140), $urandom_range(0, 140));
    end
    stream_pixels();

    // Directed eats: pellet twice, wall, power.
    do_eat(2, 2);
    do_eat(2, 2);
    do_eat(0, 0);
    do_eat(1, 1);
    for (int i = 0; i < 8; i++) do_eat($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));

    // Eaten tiles must now render as background.
    push_pix(40, 40);
    push_pix(20, 20);
    for (int i = 0; i < 100; i++) push_pix($urandom_range(0, 130), $urandom_range(0, 130));
    stream_pixels();

    // Clear the level.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (exp_map[r][c] >= 2) do_eat(r, c);
    check("level_clear_set", int'(bus.level_clear), 1);

    // Restart; a pixel issued during INIT renders background.
    do_restart();
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'd20;
    bus.pix_y     = 10'd4;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    check("init_pix_color", int'(bus.color), int'(BG_COLOR));
    check("init_pix_valid", int'(bus.color_valid), 1);
    wait_run("restart_cycles", 2);

    // Restart aborts an eat in progress.
    bus.eat_valid = 1'b1;
    bus.eat_row   = 3'd2;
    bus.eat_col   = 3'd3;
    @(posedge clk); #1;
    bus.eat_valid = 1'b0;
    bus.restart   = 1'b1;
    @(posedge clk); #1;
    bus.restart   = 1'b0;
    check("abort_eat_done", int'(bus.eat_done), 0);
    check("abort_pellets", int'(bus.pellets_left), 0);
    load_layout();
    wait_run("abort_cycles", 0);

    // Reset asserted mid-eat.
    bus.eat_valid = 1'b1;
    bus.eat_row   = 3'd5;
    bus.eat_col   = 3'd5;
    @(posedge clk); #1;
    bus.eat_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_eat");
    @(posedge clk); #1;
    check("rst_mid_eat_no_done", int'(bus.eat_done), 0);
    #3 rst_n = 1'b1;
    load_layout();
    wait_run("rst_eat_cycles", 0);

    // Reset asserted mid-INIT, after a known number of layout writes.
    do_restart();
    repeat (20) @(posedge clk);
    #1;
    part = 0;
    for (int i = 0; i < 20; i++) if (exp_map[i / COLS][i % COLS] >= 2) part++;
    check("init_partial_pellets", int'(bus.pellets_left), part);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_init");
    #3 rst_n = 1'b1;
    wait_run("rst_init_cycles", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
